// File: rtl/car_game_pkg.sv
// Shared car game constants, FSM encoding and the axis clamp helper.
// Used by the car controller, renderer, obstacle and score logic.
package car_game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [9:0] TICK_ROW = 10'd480;
  localparam logic [9:0] TICK_COL = 10'd0;

  localparam int CAR_W = 32;
  localparam int CAR_H = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CRASH = 2'd2;

  typedef struct packed {
    logic coll;
    logic en;
    logic down;
    logic up;
    logic right;
    logic left;
  } ctl_t;

  // One axis step with saturation at lo/hi.
  // 11-bit math keeps pos-step and pos+step free of wrap.
  function automatic logic [9:0] step_axis(
    input logic [9:0]  pos,
    input logic        dec,
    input logic        inc,
    input logic [10:0] lo,
    input logic [10:0] hi,
    input logic [10:0] step
  );
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    r = p;
    if (dec && !inc)
      r = (p >= lo + step) ? p - step : lo;
    else if (inc && !dec)
      r = (p + step <= hi) ? p + step : hi;
    return r[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick: registered pixel-position compare plus rising-edge pulse.
// Ports: clk, reset, pix_row/pix_col in; frame_tick one-cycle pulse out.
module frame_tick_gen #(
  parameter logic [9:0] TICK_ROW = 10'd480,
  parameter logic [9:0] TICK_COL = 10'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_row,
  input  logic [9:0] pix_col,
  output logic       frame_tick
);

  logic r_cmp;
  logic r_cmp_d;
  logic r_tick;
  logic w_hit;

  assign w_hit      = (pix_row == TICK_ROW) && (pix_col == TICK_COL);
  assign frame_tick = r_tick;

  // Edge detect so a dtg that dwells on the position still
  // yields one pulse per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmp   <= 1'b0;
      r_cmp_d <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cmp   <= w_hit;
      r_cmp_d <= r_cmp;
      r_tick  <= r_cmp & ~r_cmp_d;
    end
  end

endmodule

// File: rtl/player_car_ctrl.sv
// Player car motion controller: frame-sampled moves, crash/respawn FSM.
// Ports: clk, reset, pix_row/col, buttons, game_en, collision in;
// car_yellowX/Y, car_visible, crashed, frame_tick out.
module player_car_ctrl
  import car_game_pkg::*;
#(
  parameter int ROAD_LEFT    = 160,
  parameter int ROAD_RIGHT   = 480,
  parameter int Y_MIN        = 16,
  parameter int Y_MAX        = 400,
  parameter int START_X      = 304,
  parameter int START_Y      = 400,
  parameter int STEP         = 4,
  parameter int CRASH_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_row,
  input  logic [9:0] pix_col,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       game_en,
  input  logic       collision,
  output logic [9:0] car_yellowX,
  output logic [9:0] car_yellowY,
  output logic       car_visible,
  output logic       crashed,
  output logic       frame_tick
);

  localparam logic [10:0] L_XLO  = 11'(ROAD_LEFT);
  localparam logic [10:0] L_XHI  = 11'(ROAD_RIGHT - CAR_W);
  localparam logic [10:0] L_YLO  = 11'(Y_MIN);
  localparam logic [10:0] L_YHI  = 11'(Y_MAX);
  localparam logic [10:0] L_STEP = 11'(STEP);
  localparam logic [9:0]  L_SX   = 10'(START_X);
  localparam logic [9:0]  L_SY   = 10'(START_Y);
  localparam logic [7:0]  L_CF   = 8'(CRASH_FRAMES);

  ctl_t       r_s1;
  ctl_t       r_s2;
  ctl_t       w_raw;
  logic [1:0] r_state;
  logic [7:0] r_crash_cnt;
  logic [3:0] r_blink_cnt;
  logic [3:0] w_blink_nx;
  logic       r_pend;
  logic       r_vis;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] w_nx;
  logic [9:0] w_ny;
  logic       w_tick;
  logic       w_crash;

  frame_tick_gen #(
    .TICK_ROW (TICK_ROW),
    .TICK_COL (TICK_COL)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .frame_tick (w_tick)
  );

  assign w_raw = '{coll:  collision,
                   en:    game_en,
                   down:  btn_down,
                   up:    btn_up,
                   right: btn_right,
                   left:  btn_left};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_nx = step_axis(r_x, r_s2.left, r_s2.right,
                          L_XLO, L_XHI, L_STEP);
  assign w_ny = step_axis(r_y, r_s2.up, r_s2.down,
                          L_YLO, L_YHI, L_STEP);

  // A collision seen on the tick cycle itself still counts.
  assign w_crash    = r_pend | r_s2.coll;
  assign w_blink_nx = r_blink_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_x         <= L_SX;
      r_y         <= L_SY;
      r_vis       <= 1'b1;
      r_crash_cnt <= '0;
      r_blink_cnt <= '0;
      r_pend      <= 1'b0;
    end else begin
      if (r_state == ST_RUN && r_s2.coll)
        r_pend <= 1'b1;
      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            r_x   <= L_SX;
            r_y   <= L_SY;
            r_vis <= 1'b1;
            if (r_s2.en)
              r_state <= ST_RUN;
          end
          ST_RUN: begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_crash) begin
              r_state     <= ST_CRASH;
              r_crash_cnt <= L_CF;
              r_blink_cnt <= '0;
              r_pend      <= 1'b0;
            end else if (!r_s2.en) begin
              r_state <= ST_IDLE;
            end
          end
          ST_CRASH: begin
            r_crash_cnt <= r_crash_cnt - 8'd1;
            r_blink_cnt <= w_blink_nx;
            r_vis       <= ~w_blink_nx[3];
            if (r_crash_cnt <= 8'd1) begin
              r_crash_cnt <= '0;
              r_blink_cnt <= '0;
              r_x         <= L_SX;
              r_y         <= L_SY;
              r_vis       <= 1'b1;
              r_state     <= r_s2.en ? ST_RUN : ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign car_yellowX = r_x;
  assign car_yellowY = r_y;
  assign car_visible = r_vis;
  assign crashed     = (r_state == ST_CRASH);
  assign frame_tick  = w_tick;

endmodule
